// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO-side schedulers: FSM encoding and a
// width helper that never returns zero, so single-entry indices still
// get a one-bit field.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Bits needed to index n entries, minimum 1.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < n) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational round-robin find-first: returns the first set request bit
// found scanning upward from ptr, wrapping past N-1 back to 0.
module rr_prio_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    int best_dist_s;
    int dist_s;

    // Pick the requester with the smallest circular distance from ptr.
    always_comb begin
        idx         = {IW{1'b0}};
        any         = 1'b0;
        best_dist_s = N;
        dist_s      = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr)) begin
                dist_s = i - int'(ptr);
            end else begin
                dist_s = i + N - int'(ptr);
            end
            if (req[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                idx         = IW'(i);
                any         = 1'b1;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Block-oriented round-robin arbiter sharing one fifo_fwft write port among
// NUM_REQ producers. A grant is held for a whole block (until the beat
// flagged last) or MAX_BURST beats, whichever comes first. wr_en is already
// qualified with !full, so the FIFO needs no extra gating.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 128,
    localparam int GW = clog2_min1(NUM_REQ),
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_e      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [GW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic            g_valid_s;
    logic            g_last_s;
    logic [DATA_WIDTH-1:0] g_data_s;

    rr_prio_select #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_sel (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Route the currently granted requester's valid/last/data lanes.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid_s = req_valid[i];
                g_last_s  = req_last[i];
                g_data_s  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                g_valid_s = g_valid_s;
            end
        end
    end

    // Next-state logic and handshake outputs; release hands priority onward.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = {NUM_REQ{1'b0}};
        fifo_wr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_d    = pick_idx_s;
                    beat_cnt_d = {CW{1'b0}};
                    state_d    = ST_GRANT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                fifo_wr_en = g_valid_s & ~fifo_full;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (grant_q == GW'(i)) & ~fifo_full;
                end
                if (fifo_wr_en) begin
                    if (g_last_s || (beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = {CW{1'b0}};
                        if (grant_q == GW'(NUM_REQ - 1)) begin
                            rr_ptr_d = {GW{1'b0}};
                        end else begin
                            rr_ptr_d = grant_q + GW'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= {GW{1'b0}};
            rr_ptr_q   <= {GW{1'b0}};
            beat_cnt_q <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy     = (state_q == ST_GRANT);
    assign grant_id = grant_q;
    assign fifo_din = g_data_s;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requesters and the FIFO are behavioural queues;
// a rule-level model (owner, beats in grant, rotating priority) predicts the
// handshake each cycle, and the words landing in the FIFO are compared with
// the blocks each requester sent.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 128;
    localparam int IW = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic [IW-1:0]     grant_id;
    logic              busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .grant_id(grant_id),
        .busy(busy)
    );

    int checks;
    int errors;
    logic [DW:0]   rq   [N][$];
    logic [DW-1:0] sent [N][$];
    logic [DW-1:0] got  [N][$];
    logic [DW-1:0] fdat [$];
    int fsrc [$];
    int order_log [$];
    int grant_log [$];
    bit en [N];
    bit rd_en;
    int fifo_depth;
    int wr_count;
    bit m_busy;
    int m_grant, m_ptr, m_beats;

    task automatic drive_inputs();
        logic [DW:0] h;
        for (int i = 0; i < N; i++) begin
            h = '0;
            if (rq[i].size() > 0) h = rq[i][0];
            req_valid[i] = en[i] && (rq[i].size() > 0);
            req_last[i]  = h[DW];
            req_data[i*DW +: DW] = h[DW-1:0];
        end
        fifo_full = (fdat.size() >= fifo_depth);
    endtask

    task automatic add_block(input int i, input int len);
        logic [DW-1:0] d;
        for (int b = 0; b < len; b++) begin
            d = DW'($urandom);
            rq[i].push_back({(b == len - 1), d});
            sent[i].push_back(d);
        end
    endtask

    function automatic bit all_sent();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    function automatic int stream_bad(input int i);
        int bad;
        bad = 0;
        if (got[i].size() != sent[i].size()) bad = 1;
        else for (int k = 0; k < sent[i].size(); k++) if (got[i][k] !== sent[i][k]) bad++;
        return bad;
    endfunction

    task automatic drain_fifo();
        while (fdat.size() > 0) begin
            got[fsrc[0]].push_back(fdat[0]);
            void'(fdat.pop_front());
            void'(fsrc.pop_front());
        end
    endtask

    // One clock: compare DUT against the model at negedge, then advance the
    // environment (from DUT handshakes) and the model (from its own rules).
    task automatic cycle_step();
        logic [N-1:0] s_valid, s_ready, s_last, exp_ready;
        logic s_wr, s_full, s_rst, exp_wr;
        logic [DW-1:0] s_din, exp_din;
        logic [DW:0] h;
        int s_gid;
        bit found;
        @(negedge clk);
        s_rst = rst_n; s_valid = req_valid; s_ready = req_ready; s_last = req_last;
        s_wr = fifo_wr_en; s_full = fifo_full; s_din = fifo_din; s_gid = int'(grant_id);
        exp_wr = 1'b0; exp_ready = '0; exp_din = '0;
        if (m_busy) begin
            exp_wr = s_valid[m_grant] && !s_full;
            if (!s_full) exp_ready[m_grant] = 1'b1;
            if (rq[m_grant].size() > 0) begin h = rq[m_grant][0]; exp_din = h[DW-1:0]; end
        end
        if (s_rst) begin
            checks++;
            if (busy !== m_busy) begin errors++; $display("FAIL busy t=%0t got=%0b exp=%0b", $time, busy, m_busy); end
            if (m_busy) begin
                checks++;
                if (s_gid != m_grant) begin errors++; $display("FAIL grant_id t=%0t got=%0d exp=%0d", $time, s_gid, m_grant); end
            end
            checks++;
            if (s_ready !== exp_ready) begin errors++; $display("FAIL req_ready t=%0t got=%b exp=%b", $time, s_ready, exp_ready); end
            checks++;
            if (s_wr !== exp_wr) begin errors++; $display("FAIL wr_en t=%0t got=%0b exp=%0b", $time, s_wr, exp_wr); end
            checks++;
            if (s_wr && s_full) begin errors++; $display("FAIL wr_while_full t=%0t got wr=1 full=1 exp wr=0", $time); end
            if (exp_wr) begin
                checks++;
                if (s_din !== exp_din) begin errors++; $display("FAIL fifo_din t=%0t got=%h exp=%h", $time, s_din, exp_din); end
            end
        end
        @(posedge clk);
        #1;
        if (s_rst && rst_n) begin
            for (int i = 0; i < N; i++) if (s_valid[i] && s_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rd_en && fdat.size() > 0) begin
                got[fsrc[0]].push_back(fdat[0]);
                void'(fdat.pop_front());
                void'(fsrc.pop_front());
            end
            if (s_wr) begin
                fdat.push_back(s_din); fsrc.push_back(s_gid); order_log.push_back(s_gid); wr_count++;
            end
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && s_valid[j]) begin
                        found = 1'b1; m_busy = 1'b1; m_grant = j; m_beats = 0; grant_log.push_back(j);
                    end
                end
            end else if (exp_wr) begin
                m_beats++;
                if (s_last[m_grant] || m_beats == MB) begin
                    m_busy = 1'b0; m_ptr = (m_grant + 1) % N;
                end
            end
        end
        drive_inputs();
    endtask

    task automatic run_until_idle(input int budget, input string name, output int n);
        n = 0;
        while (!(all_sent() && !m_busy) && n < budget) begin cycle_step(); n++; end
        checks++;
        if (!(all_sent() && !m_busy)) begin
            errors++; $display("FAIL %s_timeout got=busy after %0d cycles exp=idle", name, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete(); sent[i].delete(); got[i].delete(); en[i] = 1'b1;
        end
        fdat.delete(); fsrc.delete(); order_log.delete(); grant_log.delete();
        rd_en = 1'b1; fifo_depth = 1024; wr_count = 0;
        m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_beats = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        rd_en = 1'b1; fifo_depth = 1024;
        add_block(0, 2);
        drive_inputs();
        #2 rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) #1; else begin @(posedge clk); #1; end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
            checks++;
            if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
            checks++;
            if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            checks++;
            if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", fifo_wr_en); end
        end
    endtask

    task automatic test_single();
        int exp_cnt;
        do_reset();
        add_block(0, 8);
        drive_inputs();
        for (int k = 0; k < 11; k++) begin
            cycle_step();
            exp_cnt = (k < 1) ? 0 : ((k > 8) ? 8 : k);
            checks++;
            if (wr_count != exp_cnt) begin errors++; $display("FAIL single_beats step=%0d got=%0d exp=%0d", k, wr_count, exp_cnt); end
        end
        drain_fifo();
        checks++;
        if (stream_bad(0) != 0) begin errors++; $display("FAIL single_stream got=%0d words bad=%0d exp=8 words bad=0", got[0].size(), stream_bad(0)); end
    endtask

    task automatic test_two();
        int n;
        do_reset();
        add_block(0, 4); add_block(2, 4);
        drive_inputs();
        run_until_idle(100, "two", n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL two_cycles got=%0d exp=10", n); end
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            errors++; $display("FAIL two_order got size=%0d first=%0d exp 0,2", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        cycle_step();
        grant_log.delete();
        add_block(2, 4); add_block(0, 4);
        drive_inputs();
        run_until_idle(100, "two_wrap", n);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 2) begin
            errors++; $display("FAIL two_wrap_order got size=%0d first=%0d exp 0,2", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        drain_fifo();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stream_bad(i) != 0) begin errors++; $display("FAIL two_stream r%0d got bad=%0d exp=0", i, stream_bad(i)); end
        end
    endtask

    task automatic test_all_rr();
        int n, bad;
        do_reset();
        for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) add_block(i, 3);
        drive_inputs();
        run_until_idle(200, "all_rr", n);
        bad = (grant_log.size() != 8) ? 1 : 0;
        for (int k = 0; k < grant_log.size() && k < 8; k++) if (grant_log[k] != k % N) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL all_rr_grants got bad=%0d exp=0", bad); end
        bad = (order_log.size() != 24) ? 1 : 0;
        for (int k = 0; k < order_log.size() && k < 24; k++) if (order_log[k] != (k / 3) % N) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL all_rr_interleave got bad=%0d exp=0", bad); end
        drain_fifo();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stream_bad(i) != 0) begin errors++; $display("FAIL all_rr_stream r%0d got bad=%0d exp=0", i, stream_bad(i)); end
        end
    endtask

    task automatic test_max_burst();
        int n, bad, e;
        do_reset();
        add_block(1, 300); add_block(3, 5);
        drive_inputs();
        run_until_idle(1000, "max_burst", n);
        checks++;
        if (grant_log.size() != 4 || grant_log[0] != 1 || grant_log[1] != 3 || grant_log[2] != 1 || grant_log[3] != 1) begin
            errors++; $display("FAIL max_burst_grants got size=%0d exp 1,3,1,1", grant_log.size());
        end
        bad = (order_log.size() != 305) ? 1 : 0;
        for (int k = 0; k < order_log.size() && k < 305; k++) begin
            e = (k >= 128 && k < 133) ? 3 : 1;
            if (order_log[k] != e) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL max_burst_order got bad=%0d exp=0", bad); end
        drain_fifo();
        for (int i = 1; i < N; i += 2) begin
            checks++;
            if (stream_bad(i) != 0) begin errors++; $display("FAIL max_burst_stream r%0d got bad=%0d exp=0", i, stream_bad(i)); end
        end
    endtask

    task automatic test_full();
        int n;
        do_reset();
        fifo_depth = 16; rd_en = 1'b0;
        add_block(0, 20);
        drive_inputs();
        repeat (40) cycle_step();
        checks++;
        if (fdat.size() != 16) begin errors++; $display("FAIL full_level got=%0d exp=16", fdat.size()); end
        checks++;
        if (rq[0].size() != 4) begin errors++; $display("FAIL full_remaining got=%0d exp=4", rq[0].size()); end
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL full_stall got wr=%0b ready=%b busy=%0b exp 0,0000,1", fifo_wr_en, req_ready, busy);
        end
        rd_en = 1'b1;
        drive_inputs();
        run_until_idle(200, "full", n);
        drain_fifo();
        checks++;
        if (stream_bad(0) != 0) begin errors++; $display("FAIL full_stream got bad=%0d exp=0", stream_bad(0)); end
    endtask

    task automatic test_random();
        int n, k;
        do_reset();
        fifo_depth = 8;
        for (int b = 0; b < 3; b++) for (int i = 0; i < N; i++) add_block(i, $urandom_range(1, 10));
        k = 0;
        while (!(all_sent() && !m_busy) && k < 3000) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            rd_en = ($urandom_range(0, 1) != 0);
            drive_inputs();
            cycle_step();
            k++;
        end
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        rd_en = 1'b1;
        drive_inputs();
        run_until_idle(500, "random", n);
        drain_fifo();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stream_bad(i) != 0) begin errors++; $display("FAIL random_stream r%0d got bad=%0d exp=0", i, stream_bad(i)); end
        end
    endtask

    task automatic test_mid_reset();
        int n, k;
        do_reset();
        add_block(0, 3);
        drive_inputs();
        run_until_idle(50, "mid_pre", n);
        add_block(1, 10);
        drive_inputs();
        wr_count = 0; k = 0;
        while (wr_count < 5 && k < 50) begin cycle_step(); k++; end
        checks++;
        if (wr_count != 5) begin errors++; $display("FAIL mid_reach_beat5 got=%0d exp=5", wr_count); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || req_ready !== 4'b0 || fifo_wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_async_reset got busy=%0b gid=%0d ready=%b wr=%0b exp all 0", busy, grant_id, req_ready, fifo_wr_en);
        end
        m_busy = 1'b0; m_grant = 0; m_ptr = 0; m_beats = 0;
        repeat (2) cycle_step();
        #2 rst_n = 1'b1;
        grant_log.delete();
        add_block(0, 4);
        drive_inputs();
        run_until_idle(100, "mid_post", n);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++; $display("FAIL mid_prio got size=%0d first=%0d exp 0,1", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        drain_fifo();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stream_bad(i) != 0) begin errors++; $display("FAIL mid_stream r%0d got bad=%0d exp=0", i, stream_bad(i)); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_two();
        test_all_rr();
        test_max_burst();
        test_full();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
